// File: rtl/enigma_pkg.sv
// Shared cipher-core types: letter code, reflector FSM states and the UKW-B wiring.
// Build option REFLECTOR_SELFMAP_EN is consumed by the reflector files, not here.
package enigma_pkg;

   localparam int N_LETTERS = 26;
   localparam int LW        = 5;

   typedef logic [LW-1:0] letter_t;

   localparam letter_t LAST_LETTER = letter_t'(N_LETTERS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      CHECK  = 2'd2,
      COMMIT = 2'd3
   } refl_state_t;

   // Power-up wiring: AY BR CU DH EQ FS GL IP JX KN MO TZ VW
   function automatic letter_t ukw_b(input letter_t idx);
      letter_t v;
      case (idx)
         5'd0:    v = 5'd24;
         5'd1:    v = 5'd17;
         5'd2:    v = 5'd20;
         5'd3:    v = 5'd7;
         5'd4:    v = 5'd16;
         5'd5:    v = 5'd18;
         5'd6:    v = 5'd11;
         5'd7:    v = 5'd3;
         5'd8:    v = 5'd15;
         5'd9:    v = 5'd23;
         5'd10:   v = 5'd13;
         5'd11:   v = 5'd6;
         5'd12:   v = 5'd14;
         5'd13:   v = 5'd10;
         5'd14:   v = 5'd12;
         5'd15:   v = 5'd8;
         5'd16:   v = 5'd4;
         5'd17:   v = 5'd1;
         5'd18:   v = 5'd5;
         5'd19:   v = 5'd25;
         5'd20:   v = 5'd2;
         5'd21:   v = 5'd22;
         5'd22:   v = 5'd21;
         5'd23:   v = 5'd9;
         5'd24:   v = 5'd0;
         5'd25:   v = 5'd19;
         default: v = idx;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/refl_table_check.sv
// Sequential scanner that walks the shadow table one entry per cycle and reports coverage/involution faults.
// With REFLECTOR_SELFMAP_EN, unwritten entries are requested as self-maps instead of being faults.
module refl_table_check
   import enigma_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_en,
   input  logic [N_LETTERS*LW-1:0] i_shadow,
   input  logic [N_LETTERS-1:0]    i_mask,
   output logic                    o_done,
   output logic                    o_bad,
   output logic                    o_fix,
   output logic [LW-1:0]           o_idx
);

   letter_t r_idx;
   logic    r_bad;
   letter_t w_cur;
   letter_t w_back;
   logic    w_cov;
   logic    w_entry_bad;

   always_comb begin
      w_cur = '0;
      w_cov = 1'b0;
      for (int i = 0; i < N_LETTERS; i++) begin
         w_cur = (r_idx == letter_t'(i)) ? i_shadow[i*LW +: LW] : w_cur;
         w_cov = (r_idx == letter_t'(i)) ? i_mask[i] : w_cov;
      end
   end

   always_comb begin
      w_back = '0;
      for (int j = 0; j < N_LETTERS; j++) begin
         w_back = (w_cur == letter_t'(j)) ? i_shadow[j*LW +: LW] : w_back;
      end
   end

   // o_bad folds in the current entry so it is final in the o_done cycle
   always_comb begin
`ifdef REFLECTOR_SELFMAP_EN
      w_entry_bad = w_cov && ((w_cur > LAST_LETTER) || (w_back != r_idx));
      o_fix       = i_en && !w_cov;
`else
      w_entry_bad = !w_cov || (w_cur > LAST_LETTER) || (w_back != r_idx);
      o_fix       = 1'b0;
`endif
      o_done = i_en && (r_idx == LAST_LETTER);
      o_bad  = r_bad || w_entry_bad;
   end

   assign o_idx = r_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx <= 5'd0;
         r_bad <= 1'b0;
      end else if (!i_en || o_done) begin
         r_idx <= 5'd0;
         r_bad <= 1'b0;
      end else begin
         r_idx <= r_idx + 5'd1;
         r_bad <= r_bad || w_entry_bad;
      end
   end

endmodule

// File: rtl/ukwd_reflector.sv
// Rewirable reflector: registered lookups on the active table, pair-loaded shadow table committed after a full scan.
// Build option REFLECTOR_SELFMAP_EN allows a==b pairs and partial loads (unwritten letters self-map).
module ukwd_reflector
   import enigma_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [LW-1:0] cfg_a,
   input  logic [LW-1:0] cfg_b,
   input  logic          cfg_last,
   output logic          cfg_done,
   output logic          cfg_err,
   input  logic          lk_valid,
   input  logic [LW-1:0] lk_in,
   output logic          lk_out_valid,
   output logic [LW-1:0] lk_out
);

   refl_state_t r_state;
   refl_state_t w_next;
   letter_t     r_active [N_LETTERS];
   letter_t     r_shadow [N_LETTERS];
   logic [N_LETTERS-1:0]    r_mask;
   logic                    r_bad;
   logic                    r_cfg_ready;
   logic                    r_cfg_done;
   logic                    r_cfg_err;
   logic                    r_lk_out_valid;
   letter_t                 r_lk_out;

   logic                    w_beat;
   logic                    w_a_ok;
   logic                    w_b_ok;
   logic                    w_a_seen;
   logic                    w_b_seen;
   logic                    w_same;
   logic                    w_beat_bad;
   logic                    w_ready_next;
   logic [N_LETTERS-1:0]    w_mask_base;
   logic [N_LETTERS-1:0]    w_mask_new;
   logic [N_LETTERS*LW-1:0] w_shadow_flat;
   letter_t                 w_lk_res;
   logic                    w_chk_done;
   logic                    w_chk_bad;
   logic                    w_chk_fix;
   logic [LW-1:0]           w_chk_idx;

   assign w_beat = cfg_valid && r_cfg_ready;
   assign w_a_ok = (cfg_a <= LAST_LETTER);
   assign w_b_ok = (cfg_b <= LAST_LETTER);

   // A new load starts from an empty mask, so the first beat sees no duplicates
   always_comb begin
      w_mask_base = (r_state == IDLE) ? '0 : r_mask;
      w_mask_new  = w_mask_base;
      w_a_seen    = 1'b0;
      w_b_seen    = 1'b0;
      for (int i = 0; i < N_LETTERS; i++) begin
         w_a_seen      = (cfg_a == letter_t'(i)) ? w_mask_base[i] : w_a_seen;
         w_b_seen      = (cfg_b == letter_t'(i)) ? w_mask_base[i] : w_b_seen;
         w_mask_new[i] = w_mask_base[i] || (cfg_a == letter_t'(i)) || (cfg_b == letter_t'(i));
      end
`ifdef REFLECTOR_SELFMAP_EN
      w_same = 1'b0;
`else
      w_same = (cfg_a == cfg_b);
`endif
      w_beat_bad = !w_a_ok || !w_b_ok || w_a_seen || w_b_seen || w_same;
   end

   always_comb begin
      w_shadow_flat = '0;
      for (int i = 0; i < N_LETTERS; i++) begin
         w_shadow_flat[i*LW +: LW] = r_shadow[i];
      end
   end

   refl_table_check u_check (
      .clk      (clk),
      .rst      (rst),
      .i_en     (r_state == CHECK),
      .i_shadow (w_shadow_flat),
      .i_mask   (r_mask),
      .o_done   (w_chk_done),
      .o_bad    (w_chk_bad),
      .o_fix    (w_chk_fix),
      .o_idx    (w_chk_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // A single-beat load (first beat carries cfg_last) skips straight to CHECK
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_beat) begin
               w_next = cfg_last ? CHECK : LOAD;
            end else begin
               w_next = IDLE;
            end
         end
         LOAD: begin
            if (w_beat && cfg_last) begin
               w_next = CHECK;
            end else begin
               w_next = LOAD;
            end
         end
         CHECK: begin
            if (w_chk_done) begin
               w_next = COMMIT;
            end else begin
               w_next = CHECK;
            end
         end
         COMMIT:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_ready_next = (w_next == IDLE) || (w_next == LOAD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cfg_ready <= 1'b1;
         r_cfg_done  <= 1'b0;
         r_cfg_err   <= 1'b0;
      end else begin
         r_cfg_ready <= w_ready_next;
         r_cfg_done  <= (r_state == COMMIT) && !r_bad;
         if (w_beat && (r_state == IDLE)) begin
            r_cfg_err <= 1'b0;
         end else if ((r_state == COMMIT) && r_bad) begin
            r_cfg_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mask <= '0;
         r_bad  <= 1'b0;
         for (int i = 0; i < N_LETTERS; i++) begin
            r_shadow[i] <= 5'd0;
         end
      end else if (w_beat) begin
         r_mask <= w_mask_new;
         r_bad  <= ((r_state == IDLE) ? 1'b0 : r_bad) || w_beat_bad;
         for (int i = 0; i < N_LETTERS; i++) begin
            if (w_a_ok && w_b_ok && (cfg_a == letter_t'(i))) begin
               r_shadow[i] <= cfg_b;
            end else if (w_a_ok && w_b_ok && (cfg_b == letter_t'(i))) begin
               r_shadow[i] <= cfg_a;
            end
         end
      end else if (r_state == CHECK) begin
         if (w_chk_done) begin
            r_bad <= r_bad || w_chk_bad;
         end
         for (int i = 0; i < N_LETTERS; i++) begin
            if (w_chk_fix && (w_chk_idx == letter_t'(i))) begin
               r_shadow[i] <= letter_t'(i);
            end
         end
      end
   end

   // Active copy happens on the COMMIT edge, so a COMMIT-cycle lookup still reads the old wiring
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_LETTERS; i++) begin
            r_active[i] <= ukw_b(letter_t'(i));
         end
      end else if ((r_state == COMMIT) && !r_bad) begin
         for (int i = 0; i < N_LETTERS; i++) begin
            r_active[i] <= r_shadow[i];
         end
      end
   end

   always_comb begin
      w_lk_res = lk_in;
      for (int i = 0; i < N_LETTERS; i++) begin
         w_lk_res = (lk_in == letter_t'(i)) ? r_active[i] : w_lk_res;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lk_out_valid <= 1'b0;
         r_lk_out       <= 5'd0;
      end else begin
         r_lk_out_valid <= lk_valid;
         r_lk_out       <= w_lk_res;
      end
   end

   assign cfg_ready    = r_cfg_ready;
   assign cfg_done     = r_cfg_done;
   assign cfg_err      = r_cfg_err;
   assign lk_out_valid = r_lk_out_valid;
   assign lk_out       = r_lk_out;

endmodule

// File: tb/tb_ukwd_reflector.sv
// Directed bench for ukwd_reflector; expectations follow REFLECTOR_SELFMAP_EN when it is defined.
module tb_ukwd_reflector;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [4:0] cfg_a;
   logic [4:0] cfg_b;
   logic       cfg_last;
   logic       cfg_done;
   logic       cfg_err;
   logic       lk_valid;
   logic [4:0] lk_in;
   logic       lk_out_valid;
   logic [4:0] lk_out;

   int         n_pass = 0;
   int         n_total = 0;
   logic [4:0] pa [13];
   logic [4:0] pb [13];

   ukwd_reflector dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_a        (cfg_a),
      .cfg_b        (cfg_b),
      .cfg_last     (cfg_last),
      .cfg_done     (cfg_done),
      .cfg_err      (cfg_err),
      .lk_valid     (lk_valid),
      .lk_in        (lk_in),
      .lk_out_valid (lk_out_valid),
      .lk_out       (lk_out)
   );

   always #5 clk = ~clk;

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic lookup(input logic [4:0] in, output logic [4:0] got, output logic gv);
      @(negedge clk);
      lk_valid = 1'b1;
      lk_in    = in;
      @(negedge clk);
      got      = lk_out;
      gv       = lk_out_valid;
      lk_valid = 1'b0;
      lk_in    = 5'd0;
   endtask

   task automatic load_pairs(input int n);
      @(negedge clk);
      for (int k = 0; k < n; k++) begin
         cfg_valid = 1'b1;
         cfg_a     = pa[k];
         cfg_b     = pb[k];
         cfg_last  = (k == n - 1);
         @(negedge clk);
      end
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
   endtask

   task automatic wait_result(output int cyc, output logic got_done, output logic got_err);
      got_done = 1'b0;
      got_err  = 1'b0;
      cyc      = 0;
      for (int c = 1; c <= 60; c++) begin
         if (!got_done && !got_err) begin
            cyc = c;
            if (cfg_done) got_done = 1'b1;
            else if (cfg_err) got_err = 1'b1;
            else @(negedge clk);
         end
      end
   endtask

   task automatic set_ab_pairs();
      for (int k = 0; k < 13; k++) begin
         pa[k] = 5'(2 * k);
         pb[k] = 5'(2 * k + 1);
      end
   endtask

   task automatic test_reset();
      logic [4:0] got;
      logic       gv;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_total++;
      if ({cfg_ready, cfg_done, cfg_err, lk_out_valid, lk_out} !== {1'b1, 1'b1 ^ 1'b1, 1'b0, 1'b0, 5'd0})
         $display("FAIL reset_outputs got rdy=%0b done=%0b err=%0b v=%0b out=%0d want 1 0 0 0 0",
                  cfg_ready, cfg_done, cfg_err, lk_out_valid, lk_out);
      else n_pass++;
      rst = 1'b0;
      lookup(5'd0, got, gv);
      n_total++;
      if (got !== 5'd24 || gv !== 1'b1) $display("FAIL reset_lk0 got %0d v=%0b want 24 v=1", got, gv);
      else n_pass++;
      lookup(5'd1, got, gv);
      n_total++;
      if (got !== 5'd17) $display("FAIL reset_lk1 got %0d want 17", got);
      else n_pass++;
      lookup(5'd14, got, gv);
      n_total++;
      if (got !== 5'd12) $display("FAIL reset_lk14 got %0d want 12", got);
      else n_pass++;
      n_total++;
      if (cfg_err !== 1'b0) $display("FAIL reset_err got %0b want 0", cfg_err);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (lk_out_valid !== 1'b0) $display("FAIL lk_valid_drop got %0b want 0", lk_out_valid);
      else n_pass++;
   endtask

   task automatic test_passthrough();
      logic [4:0] got;
      logic       gv;
      lookup(5'd30, got, gv);
      n_total++;
      if (got !== 5'd30 || gv !== 1'b1) $display("FAIL pass_30 got %0d v=%0b want 30 v=1", got, gv);
      else n_pass++;
      lookup(5'd26, got, gv);
      n_total++;
      if (got !== 5'd26) $display("FAIL pass_26 got %0d want 26", got);
      else n_pass++;
   endtask

   task automatic test_duplicate();
      int         cyc;
      logic       d;
      logic       e;
      logic [4:0] got;
      logic       gv;
      pa[0] = 5'd0; pb[0] = 5'd1;
      pa[1] = 5'd1; pb[1] = 5'd2;
      load_pairs(2);
      wait_result(cyc, d, e);
      n_total++;
      if (d !== 1'b0 || e !== 1'b1) $display("FAIL dup_result got done=%0b err=%0b want done=0 err=1", d, e);
      else n_pass++;
      lookup(5'd0, got, gv);
      n_total++;
      if (got !== 5'd24) $display("FAIL dup_table got %0d want 24", got);
      else n_pass++;
      n_total++;
      if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) $display("FAIL dup_sticky got err=%0b rdy=%0b want 1 1", cfg_err, cfg_ready);
      else n_pass++;
   endtask

   task automatic test_load_ab();
      int         cyc;
      logic       d;
      logic       e;
      logic [4:0] got;
      logic       gv;
      set_ab_pairs();
      load_pairs(13);
      n_total++;
      if (cfg_ready !== 1'b0) $display("FAIL ab_ready_in_check got %0b want 0", cfg_ready);
      else n_pass++;
      wait_result(cyc, d, e);
      n_total++;
      if (d !== 1'b1 || cyc != 28) $display("FAIL ab_done got done=%0b at %0d want done=1 at 28", d, cyc);
      else n_pass++;
      n_total++;
      if (cfg_err !== 1'b0) $display("FAIL ab_err_cleared got %0b want 0", cfg_err);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (cfg_done !== 1'b0) $display("FAIL ab_done_pulse got %0b want 0", cfg_done);
      else n_pass++;
      lookup(5'd0, got, gv);
      n_total++;
      if (got !== 5'd1) $display("FAIL ab_lk0 got %0d want 1", got);
      else n_pass++;
      lookup(5'd25, got, gv);
      n_total++;
      if (got !== 5'd24) $display("FAIL ab_lk25 got %0d want 24", got);
      else n_pass++;
      lookup(5'd13, got, gv);
      n_total++;
      if (got !== 5'd12) $display("FAIL ab_lk13 got %0d want 12", got);
      else n_pass++;
   endtask

   task automatic test_commit_boundary();
      logic [4:0] obs [31];
      apply_reset();
      set_ab_pairs();
      lk_valid = 1'b1;
      lk_in    = 5'd0;
      load_pairs(13);
      for (int k = 1; k <= 30; k++) begin
         obs[k] = lk_out;
         @(negedge clk);
      end
      lk_valid = 1'b0;
      n_total++;
      if (obs[27] !== 5'd24) $display("FAIL commit_check_cycle got %0d want 24", obs[27]);
      else n_pass++;
      n_total++;
      if (obs[28] !== 5'd24) $display("FAIL commit_cycle_old got %0d want 24", obs[28]);
      else n_pass++;
      n_total++;
      if (obs[29] !== 5'd1) $display("FAIL commit_next_new got %0d want 1", obs[29]);
      else n_pass++;
   endtask

   task automatic test_reset_mid_load();
      int         cyc;
      logic       d;
      logic       e;
      logic [4:0] got;
      logic       gv;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         cfg_valid = 1'b1;
         cfg_a     = 5'(2 * k + 1);
         cfg_b     = 5'(2 * k + 2);
         cfg_last  = 1'b0;
         @(negedge clk);
      end
      cfg_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_total++;
      if (cfg_ready !== 1'b1) $display("FAIL midrst_ready got %0b want 1", cfg_ready);
      else n_pass++;
      lookup(5'd0, got, gv);
      n_total++;
      if (got !== 5'd24) $display("FAIL midrst_lk0 got %0d want 24", got);
      else n_pass++;
      lookup(5'd2, got, gv);
      n_total++;
      if (got !== 5'd20) $display("FAIL midrst_lk2 got %0d want 20", got);
      else n_pass++;
      wait_result(cyc, d, e);
      n_total++;
      if (d !== 1'b0 || e !== 1'b0) $display("FAIL midrst_idle got done=%0b err=%0b want 0 0", d, e);
      else n_pass++;
   endtask

   task automatic test_selfmap();
      int         cyc;
      logic       d;
      logic       e;
      logic [4:0] got;
      logic       gv;
      apply_reset();
      for (int k = 0; k < 7; k++) begin
         pa[k] = 5'(2 * k);
         pb[k] = 5'(2 * k + 1);
      end
      pa[7] = 5'd14; pb[7] = 5'd14;
      for (int k = 8; k < 13; k++) begin
         pa[k] = 5'(2 * k - 1);
         pb[k] = 5'(2 * k);
      end
      load_pairs(13);
      wait_result(cyc, d, e);
`ifdef REFLECTOR_SELFMAP_EN
      n_total++;
      if (d !== 1'b1 || e !== 1'b0) $display("FAIL self_result got done=%0b err=%0b want 1 0", d, e);
      else n_pass++;
      lookup(5'd14, got, gv);
      n_total++;
      if (got !== 5'd14) $display("FAIL self_lk14 got %0d want 14", got);
      else n_pass++;
      lookup(5'd25, got, gv);
      n_total++;
      if (got !== 5'd25) $display("FAIL self_lk25 got %0d want 25", got);
      else n_pass++;
`else
      n_total++;
      if (d !== 1'b0 || e !== 1'b1) $display("FAIL self_result got done=%0b err=%0b want 0 1", d, e);
      else n_pass++;
      lookup(5'd14, got, gv);
      n_total++;
      if (got !== 5'd12) $display("FAIL self_lk14 got %0d want 12", got);
      else n_pass++;
`endif
      lookup(5'd16, got, gv);
      n_total++;
`ifdef REFLECTOR_SELFMAP_EN
      if (got !== 5'd15) $display("FAIL self_lk16 got %0d want 15", got);
`else
      if (got !== 5'd4) $display("FAIL self_lk16 got %0d want 4", got);
`endif
      else n_pass++;
   endtask

   task automatic test_out_of_range();
      int         cyc;
      logic       d;
      logic       e;
      logic [4:0] got;
      logic       gv;
      apply_reset();
      pa[0] = 5'd27; pb[0] = 5'd3;
      load_pairs(1);
      wait_result(cyc, d, e);
      n_total++;
      if (d !== 1'b0 || e !== 1'b1) $display("FAIL oor_result got done=%0b err=%0b want 0 1", d, e);
      else n_pass++;
      lookup(5'd3, got, gv);
      n_total++;
      if (got !== 5'd7) $display("FAIL oor_lk3 got %0d want 7", got);
      else n_pass++;
   endtask

   initial begin
      rst       = 1'b0;
      cfg_valid = 1'b0;
      cfg_a     = 5'd0;
      cfg_b     = 5'd0;
      cfg_last  = 1'b0;
      lk_valid  = 1'b0;
      lk_in     = 5'd0;
      test_reset();
      test_passthrough();
      test_duplicate();
      test_load_ab();
      test_commit_boundary();
      test_reset_mid_load();
      test_selfmap();
      test_out_of_range();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
